// File: rtl/axil_cmd_master.sv
// axil_cmd_master: turns single-word cmd requests into AXI4-Lite reads/writes, one outstanding at a time.
// Latency: cmd accepted at cycle 0, AXI valids at 1, B/R ready at 2, rsp_valid at 3 with a zero-wait slave.
// Backpressure: cmd_ready only in IDLE; rsp held until rsp_ready. AXIL_CMD_MASTER_STATS_EN adds stat counters.
module axil_cmd_master #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    M_AXI_ACLK,
    input  logic                    M_AXI_ARESETN,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_rnw,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_rnw,
    output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]              M_AXI_AWPROT,
    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    input  logic [1:0]              M_AXI_BRESP,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]              M_AXI_ARPROT,
    output logic                    M_AXI_ARVALID,
    input  logic                    M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]              M_AXI_RRESP,
    input  logic                    M_AXI_RVALID,
    output logic                    M_AXI_RREADY
`ifdef AXIL_CMD_MASTER_STATS_EN
    ,
    input  logic                    stat_clr,
    output logic [15:0]             stat_wr_cnt,
    output logic [15:0]             stat_rd_cnt,
    output logic [15:0]             stat_err_cnt
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_RESP, S_RD, S_RD_RESP, S_RSP} state_t;

    state_t                  state_q, state_d;
    logic                    live_q, live_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic                    rnw_q, rnw_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              resp_q, resp_d;
    logic                    aw_hs, w_hs;

    // live_q keeps cmd_ready low while reset is held and until the first clock after release
    assign cmd_ready     = live_q && (state_q == S_IDLE);
    assign rsp_valid     = (state_q == S_RSP);
    assign rsp_rdata     = rdata_q;
    assign rsp_resp      = resp_q;
    assign rsp_rnw       = rnw_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_AWVALID = (state_q == S_WR) && !aw_done_q;
    assign M_AXI_WVALID  = (state_q == S_WR) && !w_done_q;
    assign M_AXI_BREADY  = (state_q == S_WR_RESP);
    assign M_AXI_ARVALID = (state_q == S_RD);
    assign M_AXI_RREADY  = (state_q == S_RD_RESP);
    assign aw_hs         = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs          = M_AXI_WVALID && M_AXI_WREADY;

    always_comb begin
        state_d   = state_q;
        live_d    = 1'b1;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rnw_d     = rnw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d    = cmd_addr & ~ADDR_WIDTH'(3);
                    wdata_d   = cmd_wdata;
                    wstrb_d   = cmd_wstrb;
                    rnw_d     = cmd_rnw;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = cmd_rnw ? S_RD : S_WR;
                end
            end
            S_WR: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = S_WR_RESP;
            end
            S_WR_RESP: begin
                if (M_AXI_BVALID) begin
                    resp_d  = M_AXI_BRESP;
                    rdata_d = '0;
                    state_d = S_RSP;
                end
            end
            S_RD: begin
                if (M_AXI_ARREADY) state_d = S_RD_RESP;
            end
            S_RD_RESP: begin
                if (M_AXI_RVALID) begin
                    resp_d  = M_AXI_RRESP;
                    rdata_d = M_AXI_RDATA;
                    state_d = S_RSP;
                end
            end
            S_RSP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q   <= S_IDLE;
            live_q    <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rnw_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= '0;
        end else begin
            state_q   <= state_d;
            live_q    <= live_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rnw_q     <= rnw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end

`ifdef AXIL_CMD_MASTER_STATS_EN
    logic [15:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, err_cnt_q, err_cnt_d;
    logic        wr_inc, rd_inc, err_inc;

    always_comb begin
        wr_inc    = (state_q == S_WR_RESP) && M_AXI_BVALID;
        rd_inc    = (state_q == S_RD_RESP) && M_AXI_RVALID;
        err_inc   = (wr_inc && (M_AXI_BRESP != 2'b00)) || (rd_inc && (M_AXI_RRESP != 2'b00));
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        err_cnt_d = err_cnt_q;
        // clear has priority over a same-cycle increment
        if (stat_clr) begin
            wr_cnt_d  = '0;
            rd_cnt_d  = '0;
            err_cnt_d = '0;
        end else begin
            if (wr_inc  && (wr_cnt_q  != 16'hFFFF)) wr_cnt_d  = wr_cnt_q  + 16'd1;
            if (rd_inc  && (rd_cnt_q  != 16'hFFFF)) rd_cnt_d  = rd_cnt_q  + 16'd1;
            if (err_inc && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign stat_wr_cnt  = wr_cnt_q;
    assign stat_rd_cnt  = rd_cnt_q;
    assign stat_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master with a delay-programmable AXI4-Lite slave model.
module tb_axil_cmd_master;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_rnw;
    logic [6:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_rnw;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [6:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
`ifdef AXIL_CMD_MASTER_STATS_EN
    logic        stat_clr = 1'b0;
    logic [15:0] stat_wr_cnt, stat_rd_cnt, stat_err_cnt;
`endif

    always #5 clk = ~clk;

    axil_cmd_master #(.ADDR_WIDTH(7), .DATA_WIDTH(32)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_rnw(rsp_rnw),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
`ifdef AXIL_CMD_MASTER_STATS_EN
        , .stat_clr(stat_clr), .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt), .stat_err_cnt(stat_err_cnt)
`endif
    );

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- slave model: ready after N valid cycles, response after N cycles
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
    logic [31:0] r_data_cfg = '0;
    int          aw_wait, w_wait, ar_wait, b_wait, r_wait, b_hs_cnt, ar_cyc;
    logic        aw_got, w_got, ar_got;
    logic [6:0]  ar_seen;

    assign awready = (aw_wait >= aw_dly);
    assign wready  = (w_wait >= w_dly);
    assign arready = (ar_wait >= ar_dly);

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_wait <= 0; r_wait <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
            bvalid <= 1'b0; rvalid <= 1'b0; bresp <= 2'b00; rresp <= 2'b00; rdata <= '0;
            b_hs_cnt <= 0; ar_cyc <= 0; ar_seen <= '0;
        end else begin
            if (awvalid && awready) begin aw_got <= 1'b1; aw_wait <= 0; end
            else if (awvalid) aw_wait <= aw_wait + 1;
            if (wvalid && wready) begin w_got <= 1'b1; w_wait <= 0; end
            else if (wvalid) w_wait <= w_wait + 1;
            if (arvalid && arready) begin ar_got <= 1'b1; ar_wait <= 0; ar_seen <= araddr; end
            else if (arvalid) ar_wait <= ar_wait + 1;
            if (arvalid) ar_cyc <= ar_cyc + 1;
            if (bvalid && bready) begin
                bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_hs_cnt <= b_hs_cnt + 1;
            end else if (!bvalid && (aw_got || (awvalid && awready)) && (w_got || (wvalid && wready))) begin
                if (b_wait >= b_dly) begin bvalid <= 1'b1; bresp <= b_resp_cfg; b_wait <= 0; end
                else b_wait <= b_wait + 1;
            end
            if (rvalid && rready) begin
                rvalid <= 1'b0; ar_got <= 1'b0;
            end else if (!rvalid && (ar_got || (arvalid && arready))) begin
                if (r_wait >= r_dly) begin rvalid <= 1'b1; rdata <= r_data_cfg; rresp <= r_resp_cfg; r_wait <= 0; end
                else r_wait <= r_wait + 1;
            end
        end
    end

    // ---------------- protocol monitor: valid must hold (with stable payload) until its handshake, then drop
    logic       awv_p = 1'b0, awh_p = 1'b0, wv_p = 1'b0, wh_p = 1'b0, arv_p = 1'b0, arh_p = 1'b0;
    logic [6:0] awa_p = '0, ara_p = '0;
    logic [31:0] wd_p = '0;
    logic       viol = 1'b0;
    always @(posedge clk) begin
        if (rstn) begin
            if ((awv_p && awh_p && awvalid) || (awv_p && !awh_p && (!awvalid || awaddr != awa_p))) viol <= 1'b1;
            if ((wv_p && wh_p && wvalid) || (wv_p && !wh_p && (!wvalid || wdata != wd_p))) viol <= 1'b1;
            if ((arv_p && arh_p && arvalid) || (arv_p && !arh_p && (!arvalid || araddr != ara_p))) viol <= 1'b1;
        end
        awv_p <= awvalid; awh_p <= awvalid && awready; awa_p <= awaddr;
        wv_p  <= wvalid;  wh_p  <= wvalid && wready;   wd_p  <= wdata;
        arv_p <= arvalid; arh_p <= arvalid && arready; ara_p <= araddr;
    end

    // ---------------- driver helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic rnw, input logic [6:0] a, input logic [31:0] wd,
                            input logic [3:0] ws, output int t0);
        int n = 0;
        cmd_valid = 1'b1; cmd_rnw = rnw; cmd_addr = a; cmd_wdata = wd; cmd_wstrb = ws;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        chk("cmd_accept_in_time", 32'(n < 50), 32'd1);
        t0 = cyc;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int t0, output int lat);
        int n = 0;
        while (!rsp_valid && n < 200) begin tick(); n++; end
        chk("rsp_in_time", 32'(rsp_valid), 32'd1);
        lat = cyc - t0;
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    int  t0, lat, b0, a0;
    logic stable;

    initial begin
        cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_handshake_sigs", 32'({cmd_ready, awvalid, wvalid, arvalid, bready, rready, rsp_valid}), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_resp_rnw", 32'({rsp_resp, rsp_rnw}), 32'd0);
        chk("rst_addr_data", 32'({awaddr, wdata[15:0]}), 32'd0);
        @(negedge clk) rstn = 1'b1;
        #1;
        chk("cmd_ready_before_first_clk", 32'(cmd_ready), 32'd0);
        tick();
        chk("cmd_ready_after_first_clk", 32'(cmd_ready), 32'd1);

        // zero-wait write
        send_cmd(1'b0, 7'h0C, 32'h0000_0002, 4'hF, t0);
        chk("wr1_awvalid_c1", 32'(awvalid), 32'd1);
        chk("wr1_wvalid_c1", 32'(wvalid), 32'd1);
        chk("wr1_awaddr", 32'(awaddr), 32'h0C);
        chk("wr1_wdata", wdata, 32'h2);
        chk("wr1_wstrb_prot", 32'({wstrb, awprot}), 32'h78);
        chk("wr1_cmd_ready_busy", 32'(cmd_ready), 32'd0);
        tick();
        chk("wr1_bready_c2", 32'(bready), 32'd1);
        chk("wr1_valids_dropped_c2", 32'({awvalid, wvalid}), 32'd0);
        wait_rsp(t0, lat);
        chk("wr1_latency", 32'(lat), 32'd3);
        chk("wr1_rsp_resp", 32'(rsp_resp), 32'd0);
        chk("wr1_rsp_rnw", 32'(rsp_rnw), 32'd0);
        chk("wr1_rsp_rdata", rsp_rdata, 32'd0);
        take_rsp();
        chk("wr1_cmd_ready_c4", 32'(cmd_ready), 32'd1);
        chk("wr1_rsp_valid_low", 32'(rsp_valid), 32'd0);

        // read with 5 RVALID wait cycles
        r_dly = 5; r_data_cfg = 32'hDEAD_BEEF;
        a0 = ar_cyc;
        send_cmd(1'b1, 7'h00, 32'h0, 4'h0, t0);
        chk("rd1_arvalid_c1", 32'({arvalid, araddr, arprot}), 32'h400);
        wait_rsp(t0, lat);
        chk("rd1_arvalid_cycles", 32'(ar_cyc - a0), 32'd1);
        chk("rd1_latency", 32'(lat), 32'd8);
        chk("rd1_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("rd1_rsp_resp", 32'(rsp_resp), 32'd0);
        chk("rd1_rsp_rnw", 32'(rsp_rnw), 32'd1);
        take_rsp();
        r_dly = 0;

        // write, W handshake 3 cycles after AW
        w_dly = 3; b0 = b_hs_cnt;
        send_cmd(1'b0, 7'h24, 32'hA5A5_0001, 4'h3, t0);
        chk("wr2_wstrb", 32'(wstrb), 32'h3);
        tick();
        chk("wr2_aw_done_w_pending", 32'({awvalid, wvalid}), 32'b01);
        wait_rsp(t0, lat);
        chk("wr2_one_b_handshake", 32'(b_hs_cnt - b0), 32'd1);
        chk("wr2_rdata_zero_after_read", rsp_rdata, 32'd0);
        chk("wr2_rsp_rnw", 32'(rsp_rnw), 32'd0);
        take_rsp();
        chk("wr2_single_rsp", 32'({rsp_valid, cmd_ready}), 32'b01);

        // write, AW handshake 3 cycles after W
        w_dly = 0; aw_dly = 3; b0 = b_hs_cnt;
        send_cmd(1'b0, 7'h28, 32'h0000_1234, 4'hF, t0);
        tick();
        chk("wr3_w_done_aw_pending", 32'({awvalid, wvalid}), 32'b10);
        wait_rsp(t0, lat);
        chk("wr3_one_b_handshake", 32'(b_hs_cnt - b0), 32'd1);
        take_rsp();
        chk("wr3_single_rsp", 32'({rsp_valid, cmd_ready}), 32'b01);
        chk("valid_protocol_ok", 32'(viol), 32'd0);
        aw_dly = 0;

        // read of unaligned top address with SLVERR
        r_resp_cfg = 2'b10; r_data_cfg = 32'h0BAD_0BAD;
        send_cmd(1'b1, 7'h7F, 32'h0, 4'h0, t0);
        chk("rd2_araddr_aligned", 32'(araddr), 32'h7C);
        wait_rsp(t0, lat);
        chk("rd2_slave_saw_addr", 32'(ar_seen), 32'h7C);
        chk("rd2_rsp_resp_slverr", 32'(rsp_resp), 32'h2);
        chk("rd2_rsp_rdata", rsp_rdata, 32'h0BAD_0BAD);
        take_rsp();
        r_resp_cfg = 2'b00;
`ifdef AXIL_CMD_MASTER_STATS_EN
        chk("stat_wr_cnt_3", 32'(stat_wr_cnt), 32'd3);
        chk("stat_rd_cnt_2", 32'(stat_rd_cnt), 32'd2);
        chk("stat_err_cnt_1", 32'(stat_err_cnt), 32'd1);
`endif

        // response backpressure with a pending command
        r_data_cfg = 32'h1234_5678;
        send_cmd(1'b1, 7'h10, 32'h0, 4'h0, t0);
        cmd_valid = 1'b1; cmd_rnw = 1'b0; cmd_addr = 7'h20; cmd_wdata = 32'h55; cmd_wstrb = 4'hF;
        wait_rsp(t0, lat);
        stable = 1'b1;
        repeat (10) begin
            if (!rsp_valid || rsp_rdata != 32'h1234_5678 || !rsp_rnw || rsp_resp != 2'b00 || cmd_ready)
                stable = 1'b0;
            tick();
        end
        chk("bp_rsp_stable_cmd_blocked", 32'(stable), 32'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp_cmd_ready_after_take", 32'(cmd_ready), 32'd1);
        t0 = cyc;
        tick();
        cmd_valid = 1'b0;
        chk("bp_second_cmd_started", 32'({awvalid, awaddr}), 32'hA0);
        wait_rsp(t0, lat);
        chk("bp_second_cmd_latency", 32'(lat), 32'd3);
        take_rsp();

        // reset during an AW wait
        aw_dly = 20;
        send_cmd(1'b0, 7'h30, 32'h0000_00AA, 4'hF, t0);
        tick();
        chk("rst_mid_awvalid_pending", 32'({awvalid, wvalid}), 32'b10);
        #2 rstn = 1'b0;
        #1;
        chk("rst_mid_valids_drop", 32'({awvalid, wvalid, bready, rsp_valid, cmd_ready}), 32'd0);
        aw_dly = 0;
        tick();
        tick();
        @(negedge clk) rstn = 1'b1;
        tick();
        chk("rst_mid_cmd_ready_after", 32'(cmd_ready), 32'd1);
        b0 = b_hs_cnt;
        send_cmd(1'b0, 7'h34, 32'h0000_CAFE, 4'hF, t0);
        chk("rst_mid_next_awaddr", 32'(awaddr), 32'h34);
        wait_rsp(t0, lat);
        chk("rst_mid_next_latency", 32'(lat), 32'd3);
        chk("rst_mid_next_b", 32'(b_hs_cnt - b0), 32'd1);
        take_rsp();
`ifdef AXIL_CMD_MASTER_STATS_EN
        chk("stat_after_reset", 32'({stat_wr_cnt[7:0], stat_rd_cnt[7:0], stat_err_cnt[7:0]}), 32'h010000);
        // clear held across an erroring write: clear must win over the increments
        stat_clr = 1'b1; b_resp_cfg = 2'b11;
        send_cmd(1'b0, 7'h38, 32'h1, 4'hF, t0);
        wait_rsp(t0, lat);
        chk("wr_decerr_passthru", 32'(rsp_resp), 32'h3);
        take_rsp();
        stat_clr = 1'b0; b_resp_cfg = 2'b00;
        chk("stat_clr_wins", 32'({stat_wr_cnt, stat_err_cnt}), 32'd0);
`endif
        chk("valid_protocol_final", 32'(viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/axil_cmd_master.md
Name: axil_cmd_master

Overview:
- AXI4-Lite initiator that turns single-word commands from a local valid/ready request port into AXI4-Lite read or write transactions.
- Returns the read data and the response code on a valid/ready response port.
- Fabric-side counterpart to the 32-bit AXI-Lite register slaves. It lets PL logic (LED-divider sequencers, self-test) program and read the register banks without the PS.
- One outstanding transaction at a time.

Parameters:
ADDR_WIDTH, 7, AXI address width; matches register-slave address width.
DATA_WIDTH, 32, AXI data width; only 32 supported.

Ports:
M_AXI_ACLK  in  1  clock; all logic single clock domain
M_AXI_ARESETN  in  1  reset; asynchronous assert, active-low
cmd_valid  in  1  command request valid
cmd_ready  out  1  block can accept a command
cmd_rnw  in  1  1=read, 0=write
cmd_addr  in  ADDR_WIDTH  byte address
cmd_wdata  in  32  write data
cmd_wstrb  in  4  write byte strobes
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_rdata  out  32  read data; 0 for writes
rsp_resp  out  2  captured BRESP/RRESP
rsp_rnw  out  1  echo of command type
M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY, M_AXI_ARADDR/ARPROT/ARVALID/ARREADY, M_AXI_RDATA/RRESP/RVALID/RREADY  standard AXI4-Lite master directions and widths

Behaviour:
- Reset (async, M_AXI_ARESETN=0):
  - State goes to IDLE.
  - All AXI valid/ready outputs are 0, and rsp_valid=0.
  - rsp_rdata=0, rsp_resp=0, rsp_rnw=0, address/data registers=0.
  - cmd_ready=0 while reset is asserted, and 1 from the first clock after release.
- States: IDLE, WR, WR_RESP, RD, RD_RESP, RSP.
- cmd_ready=1 only in IDLE (decoded from the state register).
- IDLE:
  - On cmd_valid&cmd_ready, register the address with bits [1:0] forced to 0, plus wdata, wstrb and rnw.
  - Go to RD if rnw=1, else WR.
- WR:
  - AWVALID and WVALID both go to 1 in the first cycle of WR.
  - Each valid drops the cycle after its own handshake (AWVALID&AWREADY, WVALID&WREADY), independently, in either order or simultaneously.
  - Move to WR_RESP when both handshakes are done.
  - AW/W payloads stay stable while the corresponding valid is high.
- WR_RESP:
  - BREADY=1.
  - On BVALID: capture BRESP, set rsp_rdata=0, go to RSP.
- RD: ARVALID=1 until ARREADY, then go to RD_RESP.
- RD_RESP:
  - RREADY=1.
  - On RVALID: capture RDATA and RRESP, go to RSP.
- RSP:
  - rsp_valid=1, with outputs held stable until rsp_ready; then go to IDLE.
  - No new command is accepted until the response is taken.
- AWPROT=ARPROT=3'b000 always.
- Latency with zero-wait slave:
  - Command accepted at cycle 0.
  - AWVALID/WVALID/ARVALID high at cycle 1.
  - BREADY/RREADY high at cycle 2.
  - rsp_valid at cycle 3.
  - cmd_ready back at cycle 4 if rsp_ready=1 at cycle 3.
- BRESP/RRESP of SLVERR/DECERR are passed through unmodified. There is no retry.
- cmd_* inputs are ignored outside IDLE.
- Reset mid-transaction: all valids/readies drop immediately, and the transaction is abandoned. Slave reset is shared, so no orphan responses arrive.
- No combinational path from any AXI input to any AXI output.

Optional Feature:
Macro AXIL_CMD_MASTER_STATS_EN.
- Defined:
  - Adds outputs stat_wr_cnt[15:0], stat_rd_cnt[15:0] and stat_err_cnt[15:0].
  - Writes/reads increment on entry to RSP from WR_RESP/RD_RESP respectively.
  - stat_err_cnt increments when the captured resp != 2'b00.
  - All counters saturate at 16'hFFFF and reset to 0.
  - Input stat_clr (1 bit) synchronously zeroes all three. If stat_clr coincides with an increment, the clear wins.
- Undefined: these ports and counters do not exist.

Test Plan:
- Write cmd addr=0x0C, wdata=0x0000_0002, wstrb=0xF, zero-wait slave model -> AWADDR=0x0C, WDATA=0x2 at cycle 1; rsp_valid at cycle 3 with rsp_resp=0, rsp_rnw=0, rsp_rdata=0.
- Read cmd addr=0x00, slave returns 0xDEAD_BEEF after 5 RVALID wait cycles -> ARVALID for one cycle; rsp_rdata=0xDEADBEEF, rsp_resp=0, rsp_rnw=1.
- Write with WREADY delayed 3 cycles after AWREADY, then repeat with AWREADY delayed 3 after WREADY -> each valid drops only after its own handshake; exactly one B handshake; one response each.
- Read of addr=0x7F with slave returning RRESP=2'b10 -> ARADDR=0x7C; rsp_resp=2'b10 (stat_err_cnt=1 if STATS_EN).
- rsp_ready held 0 for 10 cycles, cmd_valid held 1 -> rsp outputs stable, cmd_ready=0 throughout; second command accepted the cycle after rsp_ready=1 in IDLE.
- M_AXI_ARESETN pulled low while AWVALID=1 with AWREADY=0 -> AWVALID/WVALID=0 immediately; after release cmd_ready=1 and the next write completes normally.
